// File: rtl/sweep_pkg.sv
// Shared types and constants for the truth-table sweeper.
// Holds the FSM state encoding and the default golden table.
package sweep_pkg;

  localparam int N_VECT = 16;
  localparam int IDX_W  = 4;

  localparam logic [N_VECT-1:0] GOLDEN_DEF = 16'hD0C4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_e;

endpackage

// File: rtl/truth_table_sweep.sv
// Clocked 4-input vector sweeper that captures s into a truth table.
// Optional golden compare is built in with `define SWEEP_CHECK_EN.
module truth_table_sweep
  import sweep_pkg::*;
#(
  parameter int unsigned       SETTLE   = 1,
  parameter logic [N_VECT-1:0] EXPECTED = GOLDEN_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_s,
  output logic              o_a,
  output logic              o_b,
  output logic              o_c,
  output logic              o_d,
  output logic [IDX_W-1:0]  o_index,
  output logic              o_busy,
  output logic              o_done,
  output logic [N_VECT-1:0] o_table
`ifdef SWEEP_CHECK_EN
  ,
  output logic              o_mismatch,
  output logic [IDX_W-1:0]  o_err_index
`endif
);

  localparam logic [7:0]       SETTLE_M1 = 8'(SETTLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_VECT - 1);

  state_e              r_state;
  logic [IDX_W-1:0]    r_index;
  logic [7:0]          r_cnt;
  logic [N_VECT-1:0]   r_table;

  logic                w_accept;
  logic                w_sample;
  logic                w_last;
  logic [N_VECT-1:0]   w_table_nxt;

  assign w_accept = (r_state == S_IDLE) && i_start;
  assign w_sample = (r_state == S_SAMPLE);
  assign w_last   = (r_index == IDX_LAST);

  // Unsampled bits stay 0, so only the current index is replaced.
  always_comb begin
    w_table_nxt          = r_table;
    w_table_nxt[r_index] = i_s;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_index <= '0;
      r_cnt   <= '0;
      r_table <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_WAIT;
            r_index <= '0;
            r_cnt   <= '0;
            r_table <= '0;
          end
        end
        S_WAIT: begin
          if (r_cnt == SETTLE_M1) begin
            r_state <= S_SAMPLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_SAMPLE: begin
          r_table <= w_table_nxt;
          if (w_last) begin
            r_state <= S_DONE;
          end else begin
            r_index <= r_index + 1'b1;
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Vector bits follow the index, so they hold 1111 after a sweep.
  assign {o_a, o_b, o_c, o_d} = r_index;

  assign o_index = r_index;
  assign o_table = r_table;
  assign o_busy  = (r_state == S_WAIT) || (r_state == S_SAMPLE);
  assign o_done  = (r_state == S_DONE);

`ifdef SWEEP_CHECK_EN
  logic             r_mismatch;
  logic             r_err_seen;
  logic [IDX_W-1:0] r_err_index;
  logic             w_bit_bad;

  assign w_bit_bad = (i_s != EXPECTED[r_index]);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mismatch  <= 1'b0;
      r_err_seen  <= 1'b0;
      r_err_index <= '0;
    end else if (w_accept) begin
      r_mismatch  <= 1'b0;
      r_err_seen  <= 1'b0;
      r_err_index <= '0;
    end else if (w_sample) begin
      if (w_bit_bad && !r_err_seen) begin
        r_err_seen  <= 1'b1;
        r_err_index <= r_index;
      end
      if (w_last) begin
        r_mismatch <= (w_table_nxt != EXPECTED);
      end
    end
  end

  assign o_mismatch  = r_mismatch;
  assign o_err_index = r_err_index;
`else
  logic w_unused_expected;
  assign w_unused_expected = ^EXPECTED;
`endif

endmodule

// File: tb/tb_truth_table_sweep.sv
// Directed bench for truth_table_sweep with a table scoreboard.
// Two instances: SETTLE=1 with the reference function, SETTLE=3.
module tb_truth_table_sweep;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic st1 = 1'b0;
  logic st3 = 1'b0;
  logic inj_en = 1'b0;
  logic tie3 = 1'b1;

  logic s1, s3;
  logic a1, b1, c1, d1;
  logic a3, b3, c3, d3;
  logic [3:0]  idx1, idx3;
  logic        bz1, bz3, dn1, dn3;
  logic [15:0] tb1, tb3;
`ifdef SWEEP_CHECK_EN
  logic       mm1, mm3;
  logic [3:0] ei1, ei3;
`endif

  int n_run  = 0;
  int n_fail = 0;
  int k;
  logic [15:0] sb1[$];
  logic [15:0] sb3[$];
  logic [15:0] ref_tab;

  always #5 clk = ~clk;

  function automatic logic f(logic a, logic b, logic c, logic d);
    return (a | c) & (c | ~d) & (~a | b) & (b | ~d);
  endfunction

  function automatic logic [15:0] model();
    logic [15:0] t;
    logic [3:0]  v;
    t = '0;
    for (int i = 0; i < 16; i++) begin
      v = i[3:0];
      t[i] = f(v[3], v[2], v[1], v[0]);
    end
    return t;
  endfunction

  assign s1 = f(a1, b1, c1, d1) ^ (inj_en && idx1 == 4'd5);
  assign s3 = tie3 ? 1'b1 : f(a3, b3, c3, d3);

  truth_table_sweep #(.SETTLE(1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_start(st1), .i_s(s1),
    .o_a(a1), .o_b(b1), .o_c(c1), .o_d(d1),
    .o_index(idx1), .o_busy(bz1), .o_done(dn1), .o_table(tb1)
`ifdef SWEEP_CHECK_EN
    , .o_mismatch(mm1), .o_err_index(ei1)
`endif
  );

  truth_table_sweep #(.SETTLE(3)) dut3 (
    .i_clk(clk), .i_reset(rst), .i_start(st3), .i_s(s3),
    .o_a(a3), .o_b(b3), .o_c(c3), .o_d(d3),
    .o_index(idx3), .o_busy(bz3), .o_done(dn3), .o_table(tb3)
`ifdef SWEEP_CHECK_EN
    , .o_mismatch(mm3), .o_err_index(ei3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // k = cycles after the accepting edge; done appears at k = 16*(SETTLE+1).
  task automatic wait_done(input bit sel3, input int rp, input bit hold,
                           output int kk);
    kk = 0;
    while ((sel3 ? dn3 : dn1) !== 1'b1 && kk < 400) begin
      if (!sel3 && !hold) st1 = (kk == rp - 1);
      @(negedge clk);
      kk++;
    end
    if (!sel3 && !hold) st1 = 1'b0;
  endtask

  task automatic pulse1();
    @(negedge clk); st1 = 1'b1;
    @(negedge clk); st1 = 1'b0;
  endtask

  initial begin
    ref_tab = model();

    // reset and idle
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_table1", tb1, 16'h0);
    chk("rst_index1", idx1, 4'h0);
    chk("rst_abcd1", {a1, b1, c1, d1}, 4'h0);
    chk("rst_busy1", bz1, 1'b0);
    chk("rst_done1", dn1, 1'b0);
    chk("rst_table3", tb3, 16'h0);
    chk("rst_busy3", bz3, 1'b0);
`ifdef SWEEP_CHECK_EN
    chk("rst_mm1", mm1, 1'b0);
    chk("rst_ei1", ei1, 4'h0);
`endif

    // fault injected at vector 5
    inj_en = 1'b1;
    sb1.push_back(ref_tab ^ 16'h0020);
    pulse1();
    chk("inj_busy", bz1, 1'b1);
    wait_done(1'b0, 0, 1'b0, k);
    chk("inj_lat", k, 32);
    chk("inj_table", tb1, sb1.pop_front());
`ifdef SWEEP_CHECK_EN
    chk("inj_mm", mm1, 1'b1);
    chk("inj_ei", ei1, 4'd5);
`endif
    inj_en = 1'b0;
    @(negedge clk);
    chk("inj_done_1cyc", dn1, 1'b0);

    // clean sweep with a start re-pulse at edge 10
    sb1.push_back(ref_tab);
    pulse1();
`ifdef SWEEP_CHECK_EN
    chk("clr_mm", mm1, 1'b0);
    chk("clr_ei", ei1, 4'd0);
`endif
    wait_done(1'b0, 10, 1'b0, k);
    chk("rp_lat", k, 32);
    chk("rp_table", tb1, sb1.pop_front());
    chk("rp_busy_done", bz1, 1'b0);
    chk("rp_abcd", {a1, b1, c1, d1}, 4'hF);
`ifdef SWEEP_CHECK_EN
    chk("rp_mm", mm1, 1'b0);
`endif

    // SETTLE=3, s tied high
    tie3 = 1'b1;
    sb3.push_back(16'hFFFF);
    @(negedge clk); st3 = 1'b1;
    @(negedge clk); st3 = 1'b0;
    wait_done(1'b1, 0, 1'b0, k);
    chk("s3_lat", k, 64);
    chk("s3_table", tb3, sb3.pop_front());
`ifdef SWEEP_CHECK_EN
    chk("s3_mm", mm3, 1'b1);
    chk("s3_ei", ei3, 4'd0);
`endif

    // reset during a sweep at edge 20
    pulse1();
    repeat (10) @(negedge clk);
    chk("mid_index", idx1, 4'd5);
    chk("mid_abcd", {a1, b1, c1, d1}, 4'd5);
    chk("mid_busy", bz1, 1'b1);
    repeat (9) @(negedge clk);
    chk("mid_partial", tb1, ref_tab & 16'h01FF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_table", tb1, 16'h0);
    chk("mrst_busy", bz1, 1'b0);
    chk("mrst_abcd", {a1, b1, c1, d1}, 4'h0);
    chk("mrst_done", dn1, 1'b0);
    @(negedge clk);

    // start held high: back-to-back sweeps
    sb1.push_back(ref_tab);
    sb1.push_back(ref_tab);
    st1 = 1'b1;
    @(negedge clk);
    wait_done(1'b0, 0, 1'b1, k);
    chk("hold_lat1", k, 32);
    chk("hold_table1", tb1, sb1.pop_front());
    @(negedge clk);
    chk("hold_idle_table", tb1, ref_tab);
    chk("hold_idle_busy", bz1, 1'b0);
    @(negedge clk);
    chk("hold_clr_table", tb1, 16'h0);
    chk("hold_rearm_busy", bz1, 1'b1);
    chk("hold_rearm_idx", idx1, 4'h0);
    st1 = 1'b0;
    wait_done(1'b0, 0, 1'b0, k);
    chk("hold_lat2", k, 32);
    chk("hold_table2", tb1, sb1.pop_front());
    chk("sb_empty", sb1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
